// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one fixed-latency ROM.
// Grants are combinational. Responses come back ROM_LAT+1 cycles after the handshake, in acceptance order.
module rom_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]        rom_address,
    input  logic [DATA_W-1:0]        rom_data,
    output logic [NREQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     busy
);

    localparam int PW    = $clog2(NREQ);
    localparam int DEPTH = ROM_LAT + 1;

    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]          rom_address_q, rom_address_d;
    logic [DEPTH-1:0]           pipe_vld_q, pipe_vld_d;
    logic [DEPTH-1:0][PW-1:0]   pipe_id_q, pipe_id_d;
    logic [NREQ-1:0]            resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]          resp_data_q, resp_data_d;

    logic [NREQ-1:0]            grant;
    logic [PW-1:0]              grant_idx;
    logic [PW-1:0]              scan_idx;
    logic [ADDR_W-1:0]          sel_addr;
    logic                       hs;

    // The scan starts at rr_ptr and wraps. The first valid requester found is granted.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (grant == '0 && req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign req_ready = rst_n ? grant : '0;
    assign hs        = rst_n & (|grant);

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        rom_address_d = rom_address_q;
        if (hs) begin
            rr_ptr_d      = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
            rom_address_d = sel_addr;
        end
        pipe_vld_d = {pipe_vld_q[DEPTH-2:0], hs};
        pipe_id_d  = {pipe_id_q[DEPTH-2:0], grant_idx};
        // Stage ROM_LAT lines up with rom_data for the address issued ROM_LAT edges earlier.
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (pipe_vld_q[ROM_LAT]) begin
            resp_valid_d = NREQ'(1) << pipe_id_q[ROM_LAT];
            resp_data_d  = rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            rom_address_q <= '0;
            pipe_vld_q    <= '0;
            pipe_id_q     <= '0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            rom_address_q <= rom_address_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_id_q     <= pipe_id_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
        end
    end

    assign rom_address = rom_address_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign busy        = |pipe_vld_q;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Bench for rom_rr_arbiter: a grant table, directed corner sequences, and random traffic checked against a queue-based model.
// A second instance built with ROM_LAT=3 is used for the latency check.
module tb_rom_rr_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 7;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid, req_ready, resp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [AW-1:0]      rom_address;
    logic [DW-1:0]      rom_data, resp_data;
    logic               busy;

    logic [NREQ-1:0]    valid3, ready3, rv3;
    logic [NREQ*AW-1:0] addr3;
    logic [AW-1:0]      rom_address3;
    logic [DW-1:0]      rom_data3, rd3;
    logic               busy3;

    rom_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rom_address(rom_address), .rom_data(rom_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy));

    rom_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_addr(addr3),
        .req_ready(ready3), .rom_address(rom_address3), .rom_data(rom_data3),
        .resp_valid(rv3), .resp_data(rd3), .busy(busy3));

    function automatic logic [7:0] rom_word(input logic [6:0] a);
        return {~a[3:0], a[3:0]} ^ {1'b0, a[6:4], 4'b0000};
    endfunction

    // ROM models: data appears ROM_LAT edges after the address changes.
    logic [AW-1:0] a1_q;
    logic [AW-1:0] a3_q [3];
    always @(posedge clk) begin
        a1_q     <= rom_address;
        a3_q[0]  <= rom_address3;
        a3_q[1]  <= a3_q[0];
        a3_q[2]  <= a3_q[1];
    end
    assign rom_data  = rom_word(a1_q);
    assign rom_data3 = rom_word(a3_q[2]);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard model: the grant rule, the pointer, and a queue of expected responses with their due cycle.
    typedef struct {
        int         id;
        logic [6:0] a;
        int         due;
    } exp_t;

    exp_t           sbq[$];
    exp_t           m_e;
    int             mptr = 0;
    int             cyc = 0;
    int             m_g;
    int             n_resp = 0;
    int             n_r2 = 0;
    logic [NREQ-1:0] m_rv;
    logic [7:0]     last_d = 8'h00;

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_rom_address", rom_address, 0);
            chk("rst_busy", busy, 0);
            sbq.delete();
            mptr   = 0;
            last_d = 8'h00;
        end else begin
            m_rv = '0;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                m_e    = sbq.pop_front();
                m_rv   = NREQ'(1) << m_e.id;
                last_d = rom_word(m_e.a);
            end
            if (resp_valid != 0) n_resp++;
            if (resp_valid == 4'b0100) n_r2++;
            chk("mon_resp_valid", resp_valid, m_rv);
            chk("mon_resp_data", resp_data, last_d);
            chk("mon_busy", busy, sbq.size() != 0);
            m_g = model_grant(req_valid, mptr);
            chk("mon_req_ready", req_ready, (m_g < 0) ? 0 : (1 << m_g));
            if (m_g >= 0) begin
                m_e.id  = m_g;
                m_e.a   = req_addr[m_g*AW +: AW];
                m_e.due = cyc + 3;
                sbq.push_back(m_e);
                mptr = (m_g + 1) % NREQ;
            end
        end
    end

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    vec_t tbl[17];
    int   base;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0010};
        tbl[6]  = '{4'b1111, 4'b0100};
        tbl[7]  = '{4'b1111, 4'b1000};
        tbl[8]  = '{4'b1010, 4'b0010};
        tbl[9]  = '{4'b1010, 4'b1000};
        tbl[10] = '{4'b1010, 4'b0010};
        tbl[11] = '{4'b0000, 4'b0000};
        tbl[12] = '{4'b0011, 4'b0001};
        tbl[13] = '{4'b0011, 4'b0010};
        tbl[14] = '{4'b0101, 4'b0100};
        tbl[15] = '{4'b0110, 4'b0010};
        tbl[16] = '{4'b1001, 4'b1000};

        rst_n = 1'b1; req_valid = '0; req_addr = '0; valid3 = '0; addr3 = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("reset_ready_gated", req_ready, 0);
        chk("reset_ready3_gated", ready3, 0);
        chk("reset_busy3", busy3, 0);
        @(posedge clk); #1 req_valid = '0; rst_n = 1'b1;

        // Single read by requester 0 at address 5.
        set_addr(0, 7'd5);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("first_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("single_resp_valid", resp_valid, 4'b0001);
        chk("single_resp_data", resp_data, 8'hA5);

        do_reset();
        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            req_addr  = (NREQ*AW)'($urandom);
            @(negedge clk);
            chk($sformatf("tbl_ready_%0d", i), req_ready, tbl[i].exp_ready);
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back reads by requester 2 over every address.
        base = n_r2;
        req_valid = 4'b0100;
        for (int a = 0; a < 128; a++) begin
            set_addr(2, AW'(a));
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("sweep_resp_count", n_r2 - base, 128);

        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom);
            req_addr  = (NREQ*AW)'($urandom);
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Reset with two reads still in flight.
        set_addr(0, 7'd17);
        set_addr(1, 7'd99);
        req_valid = 4'b0001;
        @(posedge clk); #1 req_valid = 4'b0010;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_resp_data", resp_data, 0);
        chk("midrst_rom_address", rom_address, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1 req_valid = '0; rst_n = 1'b1;
        base = n_resp;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_resp_after", n_resp - base, 0);
        chk("midrst_busy_after", busy, 0);

        // ROM_LAT=3 instance: one read, response exactly four edges later.
        addr3[1*AW +: AW] = 7'd9;
        valid3 = 4'b0010;
        @(negedge clk);
        chk("lat3_grant", ready3, 4'b0010);
        @(posedge clk); #1 valid3 = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("lat3_busy_%0d", k), busy3, k < 4);
            chk($sformatf("lat3_resp_valid_%0d", k), rv3, (k == 4) ? 4'b0010 : 4'b0000);
            if (k == 4) chk("lat3_resp_data", rd3, rom_word(7'd9));
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
